// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment scanner
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam seg7_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decoder
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - 4-digit multiplexed seven-segment driver with tear-free frame commit
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int CNT_W = 17,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  output logic [3:0]  anode,
  output seg7_t       segment,
  output logic        dp,
  output logic        frame_done
);

  localparam int OFF_W = CNT_W - 2;

  logic [CNT_W-1:0] cnt;
  logic [15:0]      shadow;
  logic [15:0]      disp;
  logic             pend;

  logic [1:0]       idx;
  logic [OFF_W-1:0] offset;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [15:0]      upper;
  logic             in_guard;
  logic             lz_hide;
  logic             dark;
  seg7_t            seg_dec;

  assign idx       = cnt[CNT_W-1:CNT_W-2];
  assign offset    = cnt[OFF_W-1:0];
  assign frame_end = &cnt;
  assign nibble    = disp[{idx, 2'b00} +: 4];
  assign upper     = disp >> {idx, 2'b00};
  assign in_guard  = 32'(offset) < GUARD;

  // Digit 0 is exempt so an all-zero value still shows a single "0"
  assign lz_hide   = lz_en && (idx != 2'd0) && (upper == 16'h0000);
  assign dark      = in_guard || blank[idx] || lz_hide;

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shadow     <= '0;
      pend       <= 1'b0;
      disp       <= '0;
      anode      <= ANODE_OFF;
      segment    <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (load) begin
        shadow <= data;
        pend   <= 1'b1;
      end
      // A load on the wrap cycle bypasses the shadow so it is not lost for a frame
      if (frame_end) begin
        if (load)
          disp <= data;
        else if (pend)
          disp <= shadow;
        pend <= 1'b0;
      end
      frame_done <= frame_end;
      if (dark) begin
        anode   <= ANODE_OFF;
        segment <= SEG_BLANK;
        dp      <= 1'b1;
      end else begin
        anode   <= ~(4'b0001 << idx);
        segment <= seg_dec;
        dp      <= ~dp_in[idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan against a frame-level display model
module tb_seven_seg_scan;

  localparam int CNT_W = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 16;
  localparam int SLOT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic        frame_done;

  seven_seg_scan #(.CNT_W(CNT_W), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .load       (load),
    .dp_in      (dp_in),
    .blank      (blank),
    .lz_en      (lz_en),
    .anode      (anode),
    .segment    (segment),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: position in the frame, shown value, and a pending next value
  int          m_pos = 0;
  logic [15:0] m_shown = 16'h0;
  logic [15:0] m_next = 16'h0;
  bit          m_has_next = 0;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
     12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   d, off, digit_val, above;
    bit   off_now;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    if (rst) return e;
    d         = m_pos / SLOT;
    off       = m_pos % SLOT;
    digit_val = (int'(m_shown) / (1 << (4 * d))) % 16;
    above     = int'(m_shown) / (1 << (4 * d));
    off_now   = (off < GUARD) || blank[d] || (lz_en && d > 0 && above == 0);
    if (!off_now) begin
      e.an  = 4'hF & ~(4'(1) << d);
      e.seg = glyph(digit_val);
      e.dp  = !dp_in[d];
    end
    e.fd = (m_pos == FRAME - 1);
    return e;
  endfunction

  task automatic tick();
    exp_q.push_back(predict());
    if (rst) begin
      m_pos = 0; m_shown = 16'h0; m_next = 16'h0; m_has_next = 0;
    end else begin
      if (load) begin m_next = data; m_has_next = 1; end
      if (m_pos == FRAME - 1) begin
        if (m_has_next) m_shown = m_next;
        m_has_next = 0;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && m_pos != pos; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    data = v;
    load = 1'b1;
    tick();
  endtask

  // Monitor: every clock the DUT presents a display state; compare it to the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (anode !== e.an) begin
          errors++;
          $display("FAIL anode t=%0t got %h want %h", $time, anode, e.an);
        end
        checks++;
        if (segment !== e.seg) begin
          errors++;
          $display("FAIL segment t=%0t got %h want %h", $time, segment, e.seg);
        end
        checks++;
        if (dp !== e.dp) begin
          errors++;
          $display("FAIL dp t=%0t got %b want %b", $time, dp, e.dp);
        end
        checks++;
        if (frame_done !== e.fd) begin
          errors++;
          $display("FAIL frame_done t=%0t got %b want %b", $time, frame_done, e.fd);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(20);

    run_to(5);
    do_load(16'h1234);
    run(40);

    lz_en = 1'b1;
    do_load(16'h00A0);
    run(32);
    do_load(16'h0000);
    run(32);
    lz_en = 1'b0;

    blank = 4'b0100;
    dp_in = 4'b0001;
    do_load(16'hFFFF);
    run(32);
    blank = 4'b0000;
    dp_in = 4'b0000;

    run_to(3);
    do_load(16'hAAAA);
    run_to(15);
    do_load(16'h5555);
    run(20);

    run_to(2);
    do_load(16'h9876);
    run_to(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(24);

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      load  = ($urandom_range(0, 9) == 0);
      data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        dp_in = 4'($urandom);
        blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        lz_en = 1'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    run(4);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
